// File: rtl/ch_arb.sv
// ch_arb: round-robin arbiter for one crossbar output channel shared by 5 requesters.
// A grant is locked for a whole multi-beat transfer; accepted beats leave through one output register.
module ch_arb #(
  parameter int NUM_REQ = 5,
  parameter int DATA_W  = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      out_valid_o,
  output logic [DATA_W-1:0]         out_data_o,
  output logic                      out_last_o,
  output logic [2:0]                out_src_o,
  input  logic                      out_ready_i,
  output logic                      busy_o
);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e            state_q, state_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic [2:0]        owner_q, owner_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [2:0]        out_src_q, out_src_d;

  logic [2:0]        winner;
  logic [2:0]        cand;
  logic              any_valid;
  logic              slot_free;
  logic              accept;

  assign any_valid = |req_valid_i;
  assign slot_free = !out_valid_q || out_ready_i;
  assign accept    = (state_q == LOCK) && req_valid_i[owner_q] && slot_free;

  // Scan from the farthest candidate back to rr_ptr so the nearest valid one is assigned last and wins.
  always_comb begin
    winner = rr_ptr_q;
    cand   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = 3'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid_i[cand]) winner = cand;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values computed in always_comb.
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every output of this block gets a hold default first, so no path can infer a latch.
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          owner_d = winner;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (accept && req_last_i[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = (owner_q == 3'd4) ? 3'd0 : owner_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept and downstream pop in the same cycle simply reloads the register.
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = req_data_i[owner_q*DATA_W +: DATA_W];
      out_last_d  = req_last_i[owner_q];
      out_src_d   = owner_q;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Output logic
  always_comb begin
    req_ready_o = '0;
    if (state_q == LOCK) req_ready_o[owner_q] = slot_free;
  end

  assign busy_o      = (state_q == LOCK);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign out_src_o   = out_src_q;

endmodule

// File: tb/tb_ch_arb.sv
// Bench for ch_arb: directed scenarios plus a randomized run against a transaction-level
// round-robin model (grant order from pending requesters, beat-order scoreboard).
module tb_ch_arb;

  localparam int NR = 5;
  localparam int DW = 64;

  typedef struct packed {
    logic [2:0]    src;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic             clk_i;
  logic             rst_n_i;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready_o;
  logic             out_valid_o;
  logic [DW-1:0]    out_data_o;
  logic             out_last_o;
  logic [2:0]       out_src_o;
  logic             out_ready;
  logic             busy_o;

  ch_arb #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .out_src_o   (out_src_o),
    .out_ready_i (out_ready),
    .busy_o      (busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Per-requester stimulus state: packets left, current packet length/beat, current beat payload.
  int            pk_left[NR];
  int            pkt_len[NR];
  int            blen[NR];
  int            bidx[NR];
  logic [DW-1:0] bdata[NR];
  bit            gap[NR];
  int            or_mode;   // 0: out_ready low, 1: high, 2: random

  // Observation logs
  beat_t      acc_q[$];
  beat_t      pop_q[$];
  int         acc_cyc[$];
  int         pop_cyc[$];
  int         grant_q[$];
  logic [4:0] gmask_q[$];
  bit         busy_q[$];
  int         last_src;
  int         cyc;

  function automatic bit all_done();
    for (int i = 0; i < NR; i++) if (pk_left[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Round-robin model: first pending requester at or after ptr, circularly.
  function automatic int rr_pick(input int ptr, input logic [4:0] m);
    for (int k = 0; k < NR; k++) if (m[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  task automatic clear_logs();
    acc_q.delete(); pop_q.delete(); acc_cyc.delete(); pop_cyc.delete();
    grant_q.delete(); gmask_q.delete(); busy_q.delete();
    cyc = 0;
  endtask

  task automatic load(input int r, input int npk, input int len);
    pk_left[r] = npk;
    pkt_len[r] = len;
    bidx[r]    = 0;
    blen[r]    = (len == 0) ? int'($urandom_range(1, 4)) : len;
    bdata[r]   = {$urandom(), $urandom()};
  endtask

  // Drive one cycle at negedge, then record what the coming posedge will transfer.
  task automatic cycle();
    logic [4:0] pend;
    @(negedge clk_i);
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = (pk_left[i] > 0) && !gap[i];
      req_data[i*DW +: DW]  = bdata[i];
      req_last[i]           = (bidx[i] == blen[i] - 1);
    end
    case (or_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 99) < 70);
    endcase
    #1;
    busy_q.push_back(busy_o);
    last_src = -1;
    if (out_valid_o && out_ready) begin
      pop_q.push_back('{src: out_src_o, data: out_data_o, last: out_last_o});
      pop_cyc.push_back(cyc);
    end
    for (int i = 0; i < NR; i++) pend[i] = (pk_left[i] > 0);
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready_o[i]) begin
        if (bidx[i] == 0) begin
          grant_q.push_back(i);
          gmask_q.push_back(pend);
        end
        acc_q.push_back('{src: 3'(i), data: bdata[i], last: req_last[i]});
        acc_cyc.push_back(cyc);
        if (req_last[i]) begin
          pk_left[i]--;
          bidx[i]  = 0;
          last_src = i;
          blen[i]  = (pkt_len[i] == 0) ? int'($urandom_range(1, 4)) : pkt_len[i];
        end else begin
          bidx[i]++;
        end
        bdata[i] = {$urandom(), $urandom()};
      end
    end
    cyc++;
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (!(all_done() && !out_valid_o && !busy_o) && n < budget) begin
      cycle();
      n++;
    end
    n_cmp++;
    if (n >= budget) begin
      n_bad++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required to finish within %0d", name, n, budget);
    end
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk_i);
    rst_n_i   = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NR; i++) begin
      pk_left[i] = 0; bidx[i] = 0; gap[i] = 1'b0; blen[i] = 1; pkt_len[i] = 1;
    end
    #1;
    n_cmp++;
    if ({out_valid_o, out_last_o, busy_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL %s_flags: valid/last/busy=%b required 000", tag, {out_valid_o, out_last_o, busy_o});
    end
    n_cmp++;
    if (out_data_o !== '0 || out_src_o !== 3'd0) begin
      n_bad++;
      $display("FAIL %s_data: data=%h src=%0d required 0/0", tag, out_data_o, out_src_o);
    end
    n_cmp++;
    if (req_ready_o !== 5'b0) begin
      n_bad++;
      $display("FAIL %s_ready: req_ready=%b required 00000", tag, req_ready_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic cmp_scoreboard(input string name, input int exp_beats);
    n_cmp++;
    if (acc_q.size() != exp_beats || pop_q.size() != exp_beats) begin
      n_bad++;
      $display("FAIL %s_count: accepted=%0d output=%0d required %0d", name, acc_q.size(), pop_q.size(), exp_beats);
    end
    for (int k = 0; k < pop_q.size() && k < acc_q.size(); k++) begin
      n_cmp++;
      if (pop_q[k] !== acc_q[k]) begin
        n_bad++;
        $display("FAIL %s_beat%0d: out src=%0d data=%h last=%b required src=%0d data=%h last=%b", name, k,
                 pop_q[k].src, pop_q[k].data, pop_q[k].last, acc_q[k].src, acc_q[k].data, acc_q[k].last);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset("reset");
  endtask

  task automatic test_single();
    int t0;
    clear_logs();
    or_mode = 1;
    load(2, 1, 3);
    cycle();
    t0 = 0;
    drain(40, "single");
    cmp_scoreboard("single", 3);
    n_cmp++;
    if (acc_cyc.size() < 3 || acc_cyc[0] != t0 + 1 || pop_cyc[0] != t0 + 2) begin
      n_bad++;
      $display("FAIL single_latency: first accept cyc=%0d first out cyc=%0d required %0d/%0d",
               acc_cyc.size() ? acc_cyc[0] : -1, pop_cyc.size() ? pop_cyc[0] : -1, t0 + 1, t0 + 2);
    end
    for (int k = 0; k < pop_q.size(); k++) begin
      n_cmp++;
      if (pop_q[k].src !== 3'd2 || pop_cyc[k] != pop_cyc[0] + k) begin
        n_bad++;
        $display("FAIL single_src%0d: src=%0d cyc=%0d required src=2 cyc=%0d", k, pop_q[k].src, pop_cyc[k], pop_cyc[0] + k);
      end
    end
    if (acc_cyc.size() == 3) begin
      n_cmp++;
      if (busy_q[acc_cyc[2]] !== 1'b1 || busy_q[acc_cyc[2] + 1] !== 1'b0) begin
        n_bad++;
        $display("FAIL single_busy_fall: busy at/after last=%b%b required 10", busy_q[acc_cyc[2]], busy_q[acc_cyc[2] + 1]);
      end
    end
  endtask

  // Pointer is 3 after the requester-2 transfer: requester 4 must beat requester 1.
  task automatic test_rr_from_3();
    clear_logs();
    or_mode = 1;
    load(1, 1, 1);
    load(4, 1, 1);
    drain(40, "rr3");
    n_cmp++;
    if (grant_q.size() != 2 || grant_q[0] != 4 || grant_q[1] != 1) begin
      n_bad++;
      $display("FAIL rr3_order: got %0d grants first=%0d second=%0d required 4 then 1",
               grant_q.size(), grant_q.size() > 0 ? grant_q[0] : -1, grant_q.size() > 1 ? grant_q[1] : -1);
    end
    cmp_scoreboard("rr3", 2);
  endtask

  task automatic test_all_five();
    int exp_order[6] = '{0, 1, 2, 3, 4, 0};
    apply_reset("reset2");
    clear_logs();
    or_mode = 1;
    load(0, 2, 1);
    for (int i = 1; i < NR; i++) load(i, 1, 1);
    drain(60, "all5");
    n_cmp++;
    if (grant_q.size() != 6) begin
      n_bad++;
      $display("FAIL all5_grants: got %0d grants required 6", grant_q.size());
    end
    for (int k = 0; k < 6 && k < grant_q.size(); k++) begin
      n_cmp++;
      if (grant_q[k] != exp_order[k]) begin
        n_bad++;
        $display("FAIL all5_order%0d: granted %0d required %0d", k, grant_q[k], exp_order[k]);
      end
    end
    for (int k = 0; k + 1 < acc_cyc.size(); k++) begin
      n_cmp++;
      if (acc_cyc[k + 1] - acc_cyc[k] != 2 || busy_q[acc_cyc[k] + 1] !== 1'b0) begin
        n_bad++;
        $display("FAIL all5_bubble%0d: spacing=%0d idle=%b required 2 cycles with one idle", k,
                 acc_cyc[k + 1] - acc_cyc[k], !busy_q[acc_cyc[k] + 1]);
      end
    end
    cmp_scoreboard("all5", 6);
  endtask

  task automatic test_stall();
    int    n = 0;
    beat_t snap;
    clear_logs();
    or_mode = 1;
    load(0, 1, 4);
    while (!out_valid_o && n < 10) begin cycle(); n++; end
    n_cmp++;
    if (!out_valid_o) begin
      n_bad++;
      $display("FAIL stall_start: out_valid=%b required 1 within 10 cycles", out_valid_o);
    end
    or_mode = 0;
    for (int s = 0; s < 4; s++) begin
      cycle();
      if (s == 0) snap = '{src: out_src_o, data: out_data_o, last: out_last_o};
      n_cmp++;
      if (req_ready_o !== 5'b0 || !out_valid_o ||
          snap !== beat_t'{src: out_src_o, data: out_data_o, last: out_last_o}) begin
        n_bad++;
        $display("FAIL stall_hold%0d: ready=%b valid=%b src=%0d data=%h required ready=0 valid=1 src=%0d data=%h",
                 s, req_ready_o, out_valid_o, out_src_o, out_data_o, snap.src, snap.data);
      end
    end
    or_mode = 1;
    drain(40, "stall");
    cmp_scoreboard("stall", 4);
  endtask

  // Pointer is 1 after the requester-0 transfer, so requester 1 owns and 3 must wait.
  task automatic test_owner_gap();
    int n = 0;
    int acc_before;
    clear_logs();
    or_mode = 1;
    load(1, 1, 3);
    load(3, 1, 1);
    while (bidx[1] != 1 && n < 10) begin cycle(); n++; end
    n_cmp++;
    if (bidx[1] != 1) begin
      n_bad++;
      $display("FAIL gap_start: owner beats accepted=%0d required 1 within 10 cycles", bidx[1]);
    end
    gap[1] = 1'b1;
    acc_before = acc_q.size();
    for (int s = 0; s < 3; s++) begin
      cycle();
      n_cmp++;
      if (busy_o !== 1'b1 || req_ready_o[3] !== 1'b0 || acc_q.size() != acc_before) begin
        n_bad++;
        $display("FAIL gap_hold%0d: busy=%b ready3=%b accepts=%0d required busy=1 ready3=0 accepts=%0d",
                 s, busy_o, req_ready_o[3], acc_q.size(), acc_before);
      end
    end
    gap[1] = 1'b0;
    drain(40, "gap");
    n_cmp++;
    if (grant_q.size() != 2 || grant_q[0] != 1 || grant_q[1] != 3) begin
      n_bad++;
      $display("FAIL gap_order: got %0d grants first=%0d required 1 then 3", grant_q.size(),
               grant_q.size() > 0 ? grant_q[0] : -1);
    end
    cmp_scoreboard("gap", 4);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_logs();
    or_mode = 1;
    load(2, 1, 4);
    while (!out_valid_o && n < 10) begin cycle(); n++; end
    n_cmp++;
    if (out_valid_o !== 1'b1 || busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_pre: valid=%b busy=%b required 1/1 before reset", out_valid_o, busy_o);
    end
    apply_reset("rstmid");
    clear_logs();
    load(1, 1, 1);
    load(4, 1, 1);
    drain(40, "rstmid");
    n_cmp++;
    if (grant_q.size() != 2 || grant_q[0] != 1 || grant_q[1] != 4) begin
      n_bad++;
      $display("FAIL rstmid_order: got %0d grants first=%0d required 1 then 4", grant_q.size(),
               grant_q.size() > 0 ? grant_q[0] : -1);
    end
    cmp_scoreboard("rstmid", 2);
  endtask

  task automatic test_random();
    int    model_ptr = 0;
    int    cur_owner = -1;
    int    ng = 0;
    int    n  = 0;
    int    total = 0;
    int    exp_w;
    bit    prev_stall = 1'b0;
    beat_t prev_out;
    apply_reset("reset3");
    clear_logs();
    or_mode = 2;
    for (int i = 0; i < NR; i++) load(i, int'($urandom_range(1, 4)), 0);
    while (!(all_done() && !out_valid_o && !busy_o) && n < 2000) begin
      for (int i = 0; i < NR; i++) gap[i] = (bidx[i] > 0) && ($urandom_range(0, 4) == 0);
      cycle();
      n++;
      if (grant_q.size() > ng) begin
        exp_w = rr_pick(model_ptr, gmask_q[ng]);
        n_cmp++;
        if (grant_q[ng] != exp_w) begin
          n_bad++;
          $display("FAIL rand_grant%0d: granted %0d required %0d (ptr=%0d pending=%b)", ng, grant_q[ng], exp_w,
                   model_ptr, gmask_q[ng]);
        end
        cur_owner = grant_q[ng];
        ng++;
      end
      n_cmp++;
      if (req_ready_o != 5'b0 && (!busy_o || (out_valid_o && !out_ready) || cur_owner < 0 ||
                                  req_ready_o != 5'(1 << cur_owner))) begin
        n_bad++;
        $display("FAIL rand_ready: ready=%b busy=%b valid=%b out_ready=%b owner=%0d", req_ready_o, busy_o,
                 out_valid_o, out_ready, cur_owner);
      end
      if (prev_stall) begin
        n_cmp++;
        if (!out_valid_o || prev_out !== beat_t'{src: out_src_o, data: out_data_o, last: out_last_o}) begin
          n_bad++;
          $display("FAIL rand_stall_hold: valid=%b src=%0d data=%h required held src=%0d data=%h", out_valid_o,
                   out_src_o, out_data_o, prev_out.src, prev_out.data);
        end
      end
      prev_stall = out_valid_o && !out_ready;
      prev_out   = '{src: out_src_o, data: out_data_o, last: out_last_o};
      if (last_src >= 0) begin
        model_ptr = (last_src + 1) % NR;
        cur_owner = -1;
      end
    end
    n_cmp++;
    if (n >= 2000) begin
      n_bad++;
      $display("FAIL rand_timeout: not drained after %0d cycles, required within 2000", n);
    end
    total = acc_q.size();
    cmp_scoreboard("rand", total);
  endtask

  initial begin
    rst_n_i   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    out_ready = 1'b0;
    or_mode   = 1;
    for (int i = 0; i < NR; i++) begin
      pk_left[i] = 0; pkt_len[i] = 1; blen[i] = 1; bidx[i] = 0; gap[i] = 1'b0; bdata[i] = '0;
    end
    test_reset();
    test_single();
    test_rr_from_3();
    test_all_five();
    test_stall();
    test_owner_gap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ch_arb.md
Name: ch_arb

Overview:
Round-robin arbiter for one crossbar output channel. It shares the channel among 5 requesters with valid/ready handshakes. A grant is held for a whole multi-beat transfer until the beat marked last. Accepted beats pass through one output register stage, which drives the downstream channel.

Parameters:
NUM_REQ, 5, number of requesters; fixed at 5 (3-bit pointer, indices 0..4)
DATA_W, 64, payload width per beat

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_n_i  input  1  asynchronous active-low reset
req_valid_i  input  NUM_REQ  per-requester beat valid
req_data_i  input  NUM_REQ*DATA_W  per-requester payload; requester i occupies bits [i*DATA_W +: DATA_W]
req_last_i  input  NUM_REQ  per-requester last-beat flag
req_ready_o  output  NUM_REQ  per-requester beat accept
out_valid_o  output  1  downstream beat valid (registered)
out_data_o  output  DATA_W  downstream payload (registered)
out_last_o  output  1  downstream last flag (registered)
out_src_o  output  3  index of the requester that sourced the current output beat
out_ready_i  input  1  downstream accept
busy_o  output  1  high while a grant is held (state LOCK)

Behaviour:
- Reset (async, rst_n_i low):
  - state=IDLE, rr_ptr=0, owner=0.
  - out_valid_o=0, out_data_o=0, out_last_o=0, out_src_o=0.
  - req_ready_o=0, busy_o=0.
  - Reset mid-transfer discards the in-flight beat and the lock; no partial state survives.
- Round-robin search (combinational):
  - Search req_valid_i in circular order rr_ptr, rr_ptr+1, ... mod 5.
  - The first set bit is the winner.
  - rr_ptr is always in 0..4; values 5..7 are unreachable.
- FSM:
  - IDLE:
    - req_ready_o=0.
    - If any req_valid_i is set: owner<=winner, go to LOCK.
    - Otherwise stay in IDLE.
  - LOCK:
    - slot_free = !out_valid_o || out_ready_i.
    - req_ready_o[owner] = slot_free; all other req_ready_o bits are 0.
    - A beat is accepted when req_valid_i[owner] && req_ready_o[owner].
    - On an accepted beat with req_last_i[owner]=1: go to IDLE and set rr_ptr<=(owner==4)?0:owner+1.
  - The owner dropping valid mid-transfer keeps the lock; there is no timeout.
  - Non-owner requests are ignored while in LOCK.
- Output register:
  - An accepted beat loads out_data_o, out_last_o and out_src_o=owner, and sets out_valid_o=1 at the next edge.
  - If no beat is accepted and out_ready_i=1, out_valid_o clears.
  - With simultaneous accept and downstream pop, the register reloads with no bubble.
  - Stalled output (out_valid_o=1, out_ready_i=0) holds all out_* stable and forces req_ready_o=0.
- Latency:
  - First request at cycle t -> LOCK at t+1 -> beat accepted at t+1 -> out_valid_o at t+2.
  - There is exactly one IDLE bubble cycle between consecutive transfers.
  - Full throughput within a transfer: 1 beat per cycle when out_ready_i=1.
- Fairness: because rr_ptr advances past the finished owner, a continuously requesting requester waits at most 4 transfers.

Test Plan:
1. Reset, single requester 2 valid for 3 beats (last on beat 3), out_ready_i=1 -> out_src_o=2 on 3 consecutive output cycles; busy_o falls after beat 3 accepted; rr_ptr=3.
2. All 5 valid with 1-beat transfers from reset -> grant order 0,1,2,3,4,0; one idle bubble between grants; rr_ptr wraps 4->0.
3. rr_ptr=3 with requesters 1 and 4 valid -> requester 4 granted first, then 1.
4. During a LOCK transfer from requester 0, hold out_ready_i=0 for 4 cycles -> out_* stable; req_ready_o=0; no beat lost or duplicated after release.
5. Owner drops req_valid_i mid-transfer for 3 cycles while requester 3 is valid -> lock held, requester 3 never gets req_ready_o; transfer completes when owner resumes.
6. Assert rst_n_i low mid-transfer with out_valid_o=1 -> out_valid_o=0 and busy_o=0 immediately; after release, a new request is granted from rr_ptr=0.
